// File: rtl/counter_ctrl_pkg.sv
// Shared encodings and defaults for the counter sequence controller.
package counter_ctrl_pkg;
  localparam int LEN_W_DEF = 8;
  localparam int Q_W_DEF   = 2;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_COUNT = 2'b10,
    OP_HOLD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE, CLR, LD, CNT, HLD, FIN
  } state_e;
endpackage

// File: rtl/counter_sequence_controller_if.sv
// Command handshake between host sequencer and counter_sequence_controller.
interface counter_sequence_controller_if #(parameter int LEN_W = 8);
  logic             Cmd_Valid;
  logic             Cmd_Ready;
  logic [1:0]       Cmd_Op;
  logic [LEN_W-1:0] Cmd_Len;

  modport master (output Cmd_Valid, Cmd_Op, Cmd_Len, input Cmd_Ready);
  modport slave  (input Cmd_Valid, Cmd_Op, Cmd_Len, output Cmd_Ready);
endinterface

// File: rtl/counter_ctrl_len_timer.sv
// Loadable down counter timing the CNT/HLD phases; never wraps below zero.
module counter_ctrl_len_timer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = len_i;
    else if (dec_i && !zero_o)     cnt_d = cnt_q - LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == LEN_W'(1));
endmodule

// File: rtl/counter_sequence_controller.sv
// Command sequencer driving Clear/Enable/Load of a 2-bit counter.
// Optional wrap monitor enabled by defining COUNTER_WRAP_MONITOR_EN.
module counter_sequence_controller
  import counter_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int Q_W   = Q_W_DEF
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  counter_sequence_controller_if.slave  cmd,
  input  logic                          Abort,
  input  logic [Q_W-1:0]                Q,
  output logic                          Clear,
  output logic                          Enable,
  output logic                          Load,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Aborted,
  output logic [Q_W-1:0]                Final_Q,
  output logic [LEN_W-1:0]              Wraps
);
  state_e           state_q, state_d;
  logic             clear_q, clear_d, enable_q, enable_d, load_q, load_d;
  logic             done_q, done_d, aborted_q, aborted_d;
  logic [Q_W-1:0]   final_q_q, final_q_d;
  logic [LEN_W-1:0] wraps_q, wraps_d;
  logic             accept, tmr_dec, tmr_zero, tmr_last;

  assign accept = cmd.Cmd_Valid && (state_q == IDLE);

  counter_ctrl_len_timer #(.LEN_W(LEN_W)) u_len_timer (
    .clk    (Clock),
    .rst_n  (Resetn),
    .load_i (accept),
    .len_i  (cmd.Cmd_Len),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero),
    .last_o (tmr_last)
  );

  always_comb begin
    state_d   = state_q;
    final_q_d = final_q_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    tmr_dec   = 1'b0;
    case (state_q)
      IDLE: if (cmd.Cmd_Valid) begin
        case (op_e'(cmd.Cmd_Op))
          OP_CLEAR: state_d = CLR;
          OP_LOAD:  state_d = LD;
          OP_COUNT: state_d = (cmd.Cmd_Len == '0) ? FIN : CNT;
          default:  state_d = (cmd.Cmd_Len == '0) ? FIN : HLD;
        endcase
      end
      CLR, LD: state_d = FIN;
      CNT, HLD: begin
        tmr_dec = 1'b1;
        if (tmr_last || tmr_zero) state_d = FIN;
      end
      FIN: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        final_q_d = Q;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including the FIN capture.
    if (Abort && state_q != IDLE) begin
      state_d   = IDLE;
      done_d    = 1'b0;
      aborted_d = 1'b1;
      final_q_d = final_q_q;
      tmr_dec   = 1'b0;
    end
    // Controls are registered from the next state so they line up with it.
    clear_d  = (state_d == CLR);
    load_d   = (state_d == LD);
    enable_d = (state_d == CLR) || (state_d == LD) || (state_d == CNT);
`ifdef COUNTER_WRAP_MONITOR_EN
    wraps_d = wraps_q;
    if (accept && op_e'(cmd.Cmd_Op) == OP_COUNT)
      wraps_d = '0;
    else if (state_q == CNT && enable_q && (&Q) && !(&wraps_q))
      wraps_d = wraps_q + LEN_W'(1);
`else
    wraps_d = '0;
`endif
  end

  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state_q   <= IDLE;
      clear_q   <= 1'b0;
      enable_q  <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      final_q_q <= '0;
      wraps_q   <= '0;
    end else begin
      state_q   <= state_d;
      clear_q   <= clear_d;
      enable_q  <= enable_d;
      load_q    <= load_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      final_q_q <= final_q_d;
      wraps_q   <= wraps_d;
    end

  assign cmd.Cmd_Ready = (state_q == IDLE);
  assign Busy    = (state_q != IDLE);
  assign Clear   = clear_q;
  assign Enable  = enable_q;
  assign Load    = load_q;
  assign Done    = done_q;
  assign Aborted = aborted_q;
  assign Final_Q = final_q_q;
  assign Wraps   = wraps_q;
endmodule

// File: tb/tb_counter_sequence_controller.sv
// Scoreboard bench: stimulus queues expected completions, monitor checks them.
module tb_counter_sequence_controller;
  localparam int LEN_W = 8;
  localparam int Q_W   = 2;
`ifdef COUNTER_WRAP_MONITOR_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef struct {
    bit abrt;
    int lat;
    int fq;
    int wr;
    int nc;
    int ne;
    int nl;
  } exp_t;

  logic             Clock = 1'b0;
  logic             Resetn;
  logic             Abort;
  logic [Q_W-1:0]   Q;
  logic             Clear, Enable, Load, Busy, Done, Aborted;
  logic [Q_W-1:0]   Final_Q;
  logic [LEN_W-1:0] Wraps;

  counter_sequence_controller_if #(.LEN_W(LEN_W)) ifc ();

  counter_sequence_controller #(.LEN_W(LEN_W), .Q_W(Q_W)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .cmd     (ifc.slave),
    .Abort   (Abort),
    .Q       (Q),
    .Clear   (Clear),
    .Enable  (Enable),
    .Load    (Load),
    .Busy    (Busy),
    .Done    (Done),
    .Aborted (Aborted),
    .Final_Q (Final_Q),
    .Wraps   (Wraps)
  );

  always #5 Clock = ~Clock;

  // Behavioural model of the 2-bit counter the controller drives.
  logic [1:0] cnt = 2'd2;
  logic [1:0] ld_data = 2'd0;
  always @(posedge Clock)
    if (Enable) begin
      if (Clear)     cnt <= 2'd0;
      else if (Load) cnt <= ld_data;
      else           cnt <= cnt + 2'd1;
    end
  assign Q = cnt;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int w(input int v);
    return WRAP_EN ? v : 0;
  endfunction

  task automatic push(input bit abrt, input int lat, input int fq, input int wr,
                      input int nc, input int ne, input int nl);
    exp_t e;
    e.abrt = abrt; e.lat = lat; e.fq = fq; e.wr = wr;
    e.nc = nc; e.ne = ne; e.nl = nl;
    sb.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input int len, input int abort_cyc,
                      input bit abort_on_accept);
    int t = 0;
    while (!ifc.Cmd_Ready && t < 1000) begin @(posedge Clock); #1; t++; end
    if (t >= 1000) chk("ready_timeout", 0, 1);
    ifc.Cmd_Valid = 1'b1;
    ifc.Cmd_Op    = op;
    ifc.Cmd_Len   = LEN_W'(len);
    Abort         = abort_on_accept;
    @(posedge Clock); #1;
    ifc.Cmd_Valid = 1'b0;
    Abort         = 1'b0;
    if (abort_cyc > 0) begin
      repeat (abort_cyc - 1) begin @(posedge Clock); #1; end
      Abort = 1'b1;
      @(posedge Clock); #1;
      Abort = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},   int'(ifc.Cmd_Ready), 1);
    chk({tag, "_busy"},    int'(Busy), 0);
    chk({tag, "_clear"},   int'(Clear), 0);
    chk({tag, "_enable"},  int'(Enable), 0);
    chk({tag, "_load"},    int'(Load), 0);
    chk({tag, "_done"},    int'(Done), 0);
    chk({tag, "_aborted"}, int'(Aborted), 0);
    chk({tag, "_final_q"}, int'(Final_Q), 0);
    chk({tag, "_wraps"},   int'(Wraps), 0);
  endtask

  // Monitor: counts cycles/controls since accept, checks on Done or Aborted.
  bit   active = 0;
  int   cyc = 0, mc = 0, me = 0, ml = 0;
  exp_t e;
  always @(negedge Clock) begin
    if (!Resetn) active = 0;
    else begin
      if (active) begin
        cyc++;
        mc += int'(Clear); me += int'(Enable); ml += int'(Load);
      end
      if (Done || Aborted) begin
        if (sb.size() == 0) chk("unexpected_completion", 1, 0);
        else begin
          e = sb.pop_front();
          chk("aborted_flag", int'(Aborted), int'(e.abrt));
          chk("done_flag",    int'(Done),    int'(!e.abrt));
          chk("latency",      cyc,           e.lat);
          chk("final_q",      int'(Final_Q), e.fq);
          chk("wraps",        int'(Wraps),   e.wr);
          chk("clear_cycles", mc,            e.nc);
          chk("enable_cycles",me,            e.ne);
          chk("load_cycles",  ml,            e.nl);
        end
        active = 0;
      end
      if (ifc.Cmd_Valid && ifc.Cmd_Ready) begin
        active = 1; cyc = 0; mc = 0; me = 0; ml = 0;
      end
    end
  end

  initial begin
    int t;
    Resetn = 1'b0; Abort = 1'b0;
    ifc.Cmd_Valid = 1'b0; ifc.Cmd_Op = 2'b00; ifc.Cmd_Len = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk_reset_vals("rst");
    Resetn = 1'b1;
    @(posedge Clock); #1;

    push(0, 3, 0, 0, 1, 1, 0);        send(2'b00, 0, 0, 0);   // CLEAR from 2
    push(0, 7, 1, w(1), 0, 5, 0);     send(2'b10, 5, 0, 0);   // COUNT 5
    ld_data = 2'd3;
    push(0, 3, 3, w(1), 0, 1, 1);     send(2'b01, 0, 0, 0);   // LOAD 3
    push(0, 6, 3, w(1), 0, 0, 0);     send(2'b11, 4, 0, 0);   // HOLD 4

    t = 0;
    while (!ifc.Cmd_Ready && t < 100) begin @(posedge Clock); #1; t++; end
    Abort = 1'b1; @(posedge Clock); #1; Abort = 1'b0;   // abort while idle
    chk("abort_idle_busy", int'(Busy), 0);

    push(0, 2, 3, 0, 0, 0, 0);        send(2'b10, 0, 0, 1);   // COUNT 0 with Abort
    ld_data = 2'd2;
    push(0, 3, 2, 0, 0, 1, 1);        send(2'b01, 0, 0, 0);   // LOAD 2
    push(1, 5, 2, w(1), 0, 4, 0);     send(2'b10, 10, 4, 0);  // COUNT 10, abort cyc 4
    push(0, 257, 1, w(64), 0, 255, 0); send(2'b10, 255, 0, 0); // COUNT all-ones

    send(2'b10, 10, 0, 0);                                    // reset in CNT cycle 3
    repeat (2) begin @(posedge Clock); #1; end
    #2 Resetn = 1'b0;
    #1 chk_reset_vals("midrst");
    @(posedge Clock); #1;
    Resetn = 1'b1;
    @(posedge Clock); #1;
    chk("post_rst_ready", int'(ifc.Cmd_Ready), 1);
    push(0, 3, 0, 0, 1, 1, 0);        send(2'b00, 0, 0, 0);   // CLEAR after reset

    t = 0;
    while ((sb.size() != 0 || Busy) && t < 2000) begin @(posedge Clock); #1; t++; end
    if (t >= 2000) chk("drain_timeout", sb.size(), 0);
    repeat (2) @(posedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/counter_sequence_controller.md
# counter_sequence_controller

Command-driven sequencer for the 2-bit up counter with synchronous load, enable and clear. Accepts one command at a time over a valid/ready handshake and drives the counter's Clear, Enable and Load inputs for the required number of cycles. Observes the counter output Q and reports its value on completion. Sits between a host/test sequencer and the counter instance, so no other block toggles the counter controls directly.

## Interface
Parameters:
- LEN_W, 8, width of the command length field and of the wrap counter.
- Q_W, 2, width of the observed counter value.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  controller idle and able to accept a command.
- Cmd_Op  in  2  00 CLEAR, 01 LOAD, 10 COUNT, 11 HOLD.
- Cmd_Len  in  LEN_W  cycle count for COUNT/HOLD; ignored for CLEAR/LOAD.
- Abort  in  1  synchronous abort of the command in progress.
- Q  in  Q_W  counter output.
- Clear, Enable, Load  out  1 each  counter controls, registered.
- Busy  out  1  command in progress.
- Done  out  1  one-cycle completion pulse.
- Aborted  out  1  one-cycle abort pulse.
- Final_Q  out  Q_W  Q captured at completion, held until next completion.
- Wraps  out  LEN_W  wrap count for last COUNT (see Configuration).

## Operation
- States: IDLE, CLR, LD, CNT, HLD, FIN.
- Reset: state IDLE; Clear/Enable/Load/Busy/Done/Aborted = 0; Final_Q = 0; Wraps = 0; Cmd_Ready = 1.
- Cmd_Ready = 1 only in IDLE; accept when Cmd_Valid & Cmd_Ready. Cmd_Op/Cmd_Len latched on accept.
- CLEAR: CLR for one cycle, Clear=1 and Enable=1 together, then FIN.
- LOAD: LD for one cycle, Load=1 and Enable=1 together, then FIN.
- COUNT: CNT for exactly Cmd_Len cycles with Enable=1, Clear=Load=0, then FIN.
- HOLD: HLD for exactly Cmd_Len cycles with all controls 0, then FIN.
- Cmd_Len = 0 for COUNT/HOLD: skip directly to FIN; no Enable cycle.
- FIN: controls 0; Q sampled into Final_Q at the edge leaving FIN; Done=1 in the following cycle (IDLE).
- Busy = 1 in every state except IDLE.
- Abort in any non-IDLE state: next edge to IDLE, all controls 0, Aborted=1 for one cycle, Done not pulsed, Final_Q unchanged. Abort in IDLE has no effect. Abort and Cmd_Valid together in IDLE: command accepted.
- Resetn assertion mid-command: immediate return to reset values; no Done or Aborted.

## Timing
- Accept edge = E0. Controls are valid in the cycle after E0.
- CLEAR/LOAD: control pulse cycle 1, FIN cycle 2, Done and Cmd_Ready in cycle 3.
- COUNT/HOLD with N>0: active cycles 1..N, FIN cycle N+1, Done in cycle N+2.
- Len 0: FIN cycle 1, Done cycle 2.
- Back-to-back: a new command is acceptable in the same cycle Done is high. Minimum command spacing is therefore 3 cycles.
- Length timer is a down counter loaded with Cmd_Len and has no wrap. Any LEN_W value, including all-ones, runs to completion.

## Configuration
- COUNTER_WRAP_MONITOR_EN defined:
  - Wraps clears to 0 on accepting a COUNT.
  - Wraps increments in each CNT cycle where Enable=1 and Q is all ones, because the counter wraps on that edge.
  - Wraps saturates at all ones and is held until the next COUNT is accepted.
- Not defined: Wraps tied to 0. The port is kept so the interface stays stable.

## Structure
- Shared package counter_ctrl_pkg holds:
  - op encodings OP_CLEAR, OP_LOAD, OP_COUNT, OP_HOLD;
  - the state enum;
  - default LEN_W and Q_W constants.
- Sub-module counter_ctrl_len_timer: loadable LEN_W down counter with load, decrement and zero flag, used by CNT and HLD.

## Test plan
- Reset, then CLEAR with the counter at 2 -> Clear=Enable=1 for exactly cycle 1, Done in cycle 3, Final_Q=0.
- Clear first, then COUNT Len=5 -> Enable high exactly 5 cycles, Final_Q=1, Done at cycle 7; Wraps=1 with macro, 0 without.
- HOLD Len=4 after counter at 3 -> no control asserted, Final_Q=3, Done at cycle 6.
- COUNT Len=0 -> no Enable cycle, Done at cycle 2, Final_Q equals prior Q.
- COUNT Len=10, Abort in cycle 4 -> IDLE next cycle, Aborted pulse, no Done, Final_Q unchanged, counter advanced by 4.
- Resetn low during CNT cycle 3 -> all outputs at reset values immediately. After release, Cmd_Ready=1 and a CLEAR completes normally.
